// File: rtl/wb_cache_core_pkg.sv
// rtl/wb_cache_core_pkg.sv - shared state encoding and tree-PLRU helpers for wb_cache_core
package wb_cache_pkg;

  typedef enum logic [1:0] {IDLE, CHECK, WB, FILL} state_t;

  // Tree bits are heap-ordered: node n has children 2n+1 (left) and 2n+2 (right); 0 points left.
  function automatic int unsigned plru_victim(input int unsigned tree, input int unsigned levels);
    int unsigned node;
    int unsigned way;
    int unsigned dir;
    node = 0;
    way  = 0;
    for (int unsigned l = 0; l < 3; l++) begin
      if (l < levels) begin
        dir  = (tree >> node) & 32'd1;
        way  = (way << 1) | dir;
        node = 2 * node + 1 + dir;
      end
    end
    return way;
  endfunction

  function automatic int unsigned plru_update(input int unsigned tree, input int unsigned way,
                                              input int unsigned levels);
    int unsigned node;
    int unsigned dir;
    int unsigned t;
    node = 0;
    t    = tree;
    for (int unsigned l = 0; l < 3; l++) begin
      if (l < levels) begin
        dir  = (way >> (levels - 1 - l)) & 32'd1;
        t    = (dir != 0) ? (t & ~(32'd1 << node)) : (t | (32'd1 << node));
        node = 2 * node + 1 + dir;
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/wb_cache_core_if.sv
// rtl/wb_cache_core_if.sv - line-wide request/response bus used on both sides of the cache
interface wb_cache_core_if #(
  parameter int s_offset = 5
);
  localparam int s_mbe  = 2 ** s_offset;
  localparam int s_line = 8 * s_mbe;

  logic [31:0]       address;
  logic              read;
  logic              write;
  logic [s_line-1:0] wdata;
  logic [s_mbe-1:0]  byte_enable;
  logic [s_line-1:0] rdata;
  logic              resp;

  modport master (output address, read, write, wdata, byte_enable, input rdata, resp);
  modport slave  (input address, read, write, wdata, byte_enable, output rdata, resp);
endinterface

// File: rtl/wb_cache_core_plru_tree.sv
// rtl/wb_cache_core_plru_tree.sv - combinational tree-PLRU victim selection and access update
module plru_tree
  import wb_cache_pkg::*;
#(
  parameter int num_ways = 4,
  localparam int way_bits = (num_ways > 1) ? $clog2(num_ways) : 1,
  localparam int tree_bits = (num_ways > 1) ? num_ways - 1 : 1
) (
  input  logic [tree_bits-1:0] tree,
  input  logic [way_bits-1:0]  access_way,
  output logic [way_bits-1:0]  victim_way,
  output logic [tree_bits-1:0] next_tree
);
  // With a single way there are no levels, so the victim is 0 and the tree is left untouched.
  localparam int unsigned levels = $clog2(num_ways);

  assign victim_way = way_bits'(plru_victim(32'(tree), levels));
  assign next_tree  = tree_bits'(plru_update(32'(tree), 32'(access_way), levels));
endmodule

// File: rtl/wb_cache_core.sv
// rtl/wb_cache_core.sv - N-way set-associative write-back/write-allocate cache with miss FSM
// Optional WB_CACHE_PERF_EN adds saturating hit/miss/writeback counters.
module wb_cache_core
  import wb_cache_pkg::*;
#(
  parameter int num_ways = 4,
  parameter int s_offset = 5,
  parameter int s_index  = 3
) (
  input  logic clk,
  input  logic rst,
  wb_cache_core_if.slave  cpu,
  wb_cache_core_if.master pmem
`ifdef WB_CACHE_PERF_EN
  ,
  output logic [31:0] perf_hits,
  output logic [31:0] perf_misses,
  output logic [31:0] perf_writebacks
`endif
);
  localparam int s_tag     = 32 - s_offset - s_index;
  localparam int s_mbe     = 2 ** s_offset;
  localparam int s_line    = 8 * s_mbe;
  localparam int num_sets  = 2 ** s_index;
  localparam int way_bits  = (num_ways > 1) ? $clog2(num_ways) : 1;
  localparam int tree_bits = (num_ways > 1) ? num_ways - 1 : 1;

  logic [s_tag-1:0]     tag_q   [num_sets][num_ways];
  logic [s_line-1:0]    data_q  [num_sets][num_ways];
  logic [num_ways-1:0]  valid_q [num_sets];
  logic [num_ways-1:0]  dirty_q [num_sets];
  logic [tree_bits-1:0] plru_q  [num_sets];

  state_t              state_q, state_d;
  logic [way_bits-1:0] victim_q;

  logic                req, wr_req;
  logic [s_tag-1:0]    req_tag;
  logic [s_index-1:0]  idx;
  logic [num_ways-1:0] match;
  logic                hit;
  logic [way_bits-1:0] hit_way, first_inv, plru_way, miss_victim;
  logic [tree_bits-1:0] plru_next;
  logic [s_line-1:0]   hit_line, merged;
  logic                hit_we, fill_we, capture;
  logic                unused_offset;

  assign req           = cpu.read | cpu.write;
  assign wr_req        = cpu.write;
  assign req_tag       = cpu.address[31 -: s_tag];
  assign idx           = cpu.address[s_offset +: s_index];
  assign unused_offset = ^cpu.address[s_offset-1:0];

  always_comb begin
    match     = '0;
    hit_way   = '0;
    first_inv = '0;
    for (int w = 0; w < num_ways; w++) begin
      match[w] = valid_q[idx][w] && (tag_q[idx][w] == req_tag);
      if (match[w]) hit_way = way_bits'(w);
    end
    for (int w = num_ways - 1; w >= 0; w--) begin
      if (!valid_q[idx][w]) first_inv = way_bits'(w);
    end
    hit         = $onehot(match);
    miss_victim = (&valid_q[idx]) ? plru_way : first_inv;
  end

  plru_tree #(.num_ways(num_ways)) u_plru (
    .tree       (plru_q[idx]),
    .access_way (hit_way),
    .victim_way (plru_way),
    .next_tree  (plru_next)
  );

  always_comb begin
    hit_line = data_q[idx][hit_way];
    merged   = hit_line;
    for (int b = 0; b < s_mbe; b++) begin
      if (cpu.byte_enable[b]) merged[8*b +: 8] = cpu.wdata[8*b +: 8];
    end
  end

  always_comb begin
    state_d          = state_q;
    cpu.resp         = 1'b0;
    cpu.rdata        = '0;
    pmem.read        = 1'b0;
    pmem.write       = 1'b0;
    pmem.address     = '0;
    pmem.wdata       = '0;
    pmem.byte_enable = '0;
    hit_we           = 1'b0;
    fill_we          = 1'b0;
    capture          = 1'b0;
    case (state_q)
      IDLE: if (req) state_d = CHECK;
      CHECK: begin
        if (hit) begin
          cpu.resp  = 1'b1;
          cpu.rdata = hit_line;
          hit_we    = 1'b1;
          state_d   = IDLE;
        end else begin
          capture = 1'b1;
          state_d = (valid_q[idx][miss_victim] && dirty_q[idx][miss_victim]) ? WB : FILL;
        end
      end
      WB: begin
        pmem.write       = 1'b1;
        pmem.address     = {tag_q[idx][victim_q], idx, {s_offset{1'b0}}};
        pmem.wdata       = data_q[idx][victim_q];
        pmem.byte_enable = '1;
        if (pmem.resp) state_d = FILL;
      end
      FILL: begin
        pmem.read    = 1'b1;
        pmem.address = {req_tag, idx, {s_offset{1'b0}}};
        if (pmem.resp) begin
          fill_we = 1'b1;
          state_d = CHECK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      victim_q <= '0;
      for (int s = 0; s < num_sets; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      state_q <= state_d;
      if (capture) victim_q <= miss_victim;
      if (hit_we) begin
        plru_q[idx] <= plru_next;
        if (wr_req) dirty_q[idx][hit_way] <= 1'b1;
      end
      if (fill_we) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
    end
  end

  // Tag/data storage needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (hit_we && wr_req) data_q[idx][hit_way] <= merged;
    if (fill_we) begin
      data_q[idx][victim_q] <= pmem.rdata;
      tag_q[idx][victim_q]  <= req_tag;
    end
  end

`ifdef WB_CACHE_PERF_EN
  logic replay_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      replay_q        <= 1'b0;
      perf_hits       <= '0;
      perf_misses     <= '0;
      perf_writebacks <= '0;
    end else begin
      if (state_q == FILL && pmem.resp) replay_q <= 1'b1;
      else if (state_q == CHECK)        replay_q <= 1'b0;
      if (state_q == CHECK && hit && !replay_q && perf_hits != '1)
        perf_hits <= perf_hits + 32'd1;
      if (state_q == CHECK && !hit && perf_misses != '1)
        perf_misses <= perf_misses + 32'd1;
      if (state_q == WB && pmem.resp && perf_writebacks != '1)
        perf_writebacks <= perf_writebacks + 32'd1;
    end
  end
`endif

  // Requester must hold its request, unchanged, from acceptance until mem_resp.
  assert property (@(posedge clk) disable iff (rst)
    (state_q != IDLE) |-> ((cpu.read || cpu.write) && $stable(cpu.address)));

endmodule
